fsm_sched: RTL and testbench
============================

FSM_SCHED -- requirements
Module: fsm_sched

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-003 Parameter TIMEOUT, default 64: watchdog limit in enabled cycles, range 2..255.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  global enable; forwarded to the shared timer and gates new grants.
REQ-007 req  input  N_REQ  level request per requester.
REQ-008 gnt  output  N_REQ  one-hot grant, held for the whole job.
REQ-009 ack  output  N_REQ  one-cycle completion pulse to the granted requester.
REQ-010 err  output  1  one-cycle pulse, coincident with ack, when the job ended by watchdog.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 fsm_trigger  output  1  start pulse to the shared timer FSM.
REQ-013 fsm_en  output  1  enable to the shared timer FSM.
REQ-014 fsm_done  input  1  completion from the shared timer FSM.

Function
REQ-015 The block SHALL implement the states IDLE, TRIG, WAIT and ACK.
REQ-016 IDLE: when en=1 and req!=0, the block SHALL select a winner via round-robin starting at (last+1) mod N_REQ, register gnt one-hot next cycle, and go to TRIG.
REQ-017 IDLE with en=0 SHALL issue no grant, regardless of req.
REQ-018 TRIG: fsm_trigger=1 for exactly one cycle; the watchdog counter SHALL clear to 0; next state is WAIT.
REQ-019 WAIT: fsm_done=1 SHALL cause a move to ACK with err=0 staged.
REQ-020 WAIT: the counter SHALL increment only on cycles with en=1; when it equals TIMEOUT-1 with fsm_done=0, the block SHALL move to ACK with err=1 staged.
REQ-021 WAIT: fsm_done=1 on the same cycle the counter reaches TIMEOUT-1 SHALL count as done (err=0).
REQ-022 ACK: ack[winner]=1 and err (if staged) for one cycle; gnt SHALL clear at the end of the cycle; last SHALL take the winner index; next state is IDLE.
REQ-023 Minimum back-to-back spacing: a new trigger SHALL occur no earlier than 2 cycles after ACK (ACK -> IDLE -> TRIG).
REQ-024 A requester that deasserts req mid-job SHALL NOT abort the job; ack is still pulsed.
REQ-025 fsm_done seen in IDLE, TRIG or ACK SHALL be ignored.
REQ-026 fsm_en SHALL equal en combinationally.
REQ-027 gnt SHALL never have more than one bit set.
REQ-028 The counter width SHALL be $clog2(TIMEOUT) bits; the counter SHALL NOT wrap.

Reset
REQ-029 On rst_n=0 (asynchronous): state=IDLE, gnt=0, ack=0, err=0, busy=0, fsm_trigger=0, counter=0, last=N_REQ-1 so that requester 0 has first priority.
REQ-030 Reset mid-job SHALL drop the job with no ack or err pulse; after release, arbitration restarts from requester 0.

Structure
REQ-031 Package fsm_sched_pkg SHALL hold the state enum (IDLE, TRIG, WAIT, ACK) and the default TIMEOUT constant.
REQ-032 The round-robin selection SHALL be a combinational sub-module, rr_arbiter (inputs req and last, outputs a one-hot grant), instantiated once.

Verification
REQ-033 Reset then req=0 for 20 cycles -> gnt=0, fsm_trigger=0, busy=0 throughout.
REQ-034 req=4'b0001, timer MAX_COUNT=20 -> gnt=0001 one cycle later, a one-cycle fsm_trigger, ack=0001 the cycle after fsm_done, err=0.
REQ-035 req=4'b1111 held -> grant order 0,1,2,3,0 with exactly one ack per job.
REQ-036 fsm_done tied 0, TIMEOUT=64 -> ack plus err pulse 64 enabled cycles after TRIG.
REQ-037 en=0 during WAIT for 10 cycles with fsm_done tied 0 -> timeout is delayed by 10 cycles; en=0 in IDLE with req=0010 -> no grant until en=1.
REQ-038 rst_n pulled low in WAIT -> all outputs reach their reset values immediately; next req=1000 is granted without an ack from the aborted job.

Source files
------------

// File: rtl/fsm_sched_pkg.sv
// fsm_sched_pkg -- shared types and constants for the fsm_sched block.
//   state_t          : scheduler FSM states (IDLE, TRIG, WAIT, ACK)
//   DEFAULT_TIMEOUT  : default watchdog limit in enabled cycles
//   MAX_REQ          : largest supported requester count
//   onehot_idx()     : index of the set bit of a one-hot vector
package fsm_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRIG = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } state_t;

    localparam int DEFAULT_TIMEOUT = 64;
    localparam int MAX_REQ         = 8;

    // Returns the position of the (single) set bit; 0 for an all-zero input.
    function automatic logic [2:0] onehot_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fsm_sched_rr.sv
// rr_arbiter -- combinational round-robin selector.
//   req  [N_REQ-1:0] : level requests
//   last [LW-1:0]    : index of the previous winner
//   gnt  [N_REQ-1:0] : one-hot winner; search starts at (last+1) mod N_REQ,
//                      all zeros when nothing is requested
module rr_arbiter
    import fsm_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int LW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [LW-1:0]    last,
    output logic [N_REQ-1:0] gnt
);

    logic          found;
    logic [LW-1:0] idx;

    // Walk the ring once starting just after the last winner; the first
    // requester met wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = LW'((int'(last) + k) % N_REQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fsm_sched.sv
// fsm_sched -- grants one requester at a time a job on a shared timer FSM,
// with a watchdog that ends the job if the timer never reports done.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : global enable (forwarded as fsm_en, gates new grants,
//                  gates watchdog counting)
//   req  [N_REQ] : level requests
//   gnt  [N_REQ] : one-hot grant, held for the whole job
//   ack  [N_REQ] : one-cycle completion pulse to the granted requester
//   err          : one-cycle pulse with ack when the watchdog ended the job
//   busy         : high in every state except IDLE
//   fsm_trigger  : one-cycle start pulse to the shared timer
//   fsm_en       : enable to the shared timer (equals en)
//   fsm_done     : completion from the shared timer, honoured only in WAIT
//
// Handshake: a job is started by fsm_trigger and finished by the first
// fsm_done seen while waiting; fsm_done at any other time is ignored.
module fsm_sched
    import fsm_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] ack,
    output logic             err,
    output logic             busy,
    output logic             fsm_trigger,
    output logic             fsm_en,
    input  logic             fsm_done
);

    localparam int LW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [LW-1:0]    last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [N_REQ-1:0] arb_gnt;

    rr_arbiter #(.N_REQ(N_REQ), .LW(LW)) u_rr_arbiter (
        .req  (req),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= LW'(N_REQ - 1);  // requester 0 wins first
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (en && (|req)) begin
                    gnt_d   = arb_gnt;
                    state_d = TRIG;
                end
            end
            TRIG: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                // done wins over a watchdog expiry on the same cycle
                if (fsm_done) begin
                    err_d   = 1'b0;
                    state_d = ACK;
                end else if (en) begin
                    if (cnt_q == CNT_MAX) begin
                        err_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ACK: begin
                last_d  = LW'(onehot_idx(MAX_REQ'(gnt_q)));
                gnt_d   = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt         = gnt_q;
    assign ack         = (state_q == ACK) ? gnt_q : '0;
    assign err         = (state_q == ACK) && err_q;
    assign busy        = (state_q != IDLE);
    assign fsm_trigger = (state_q == TRIG);
    assign fsm_en      = en;

endmodule

// File: tb/tb_fsm_sched.sv
// tb_fsm_sched -- directed and random stimulus for fsm_sched against a
// job-level reference model; a stub of the shared timer answers triggers.
module tb_fsm_sched;

    localparam int N  = 4;
    localparam int TO = fsm_sched_pkg::DEFAULT_TIMEOUT;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [N-1:0] req = '0;
    logic         fsm_done = 1'b0;
    logic [N-1:0] gnt, ack;
    logic         err, busy, fsm_trigger, fsm_en;

    fsm_sched #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req         (req),
        .gnt         (gnt),
        .ack         (ack),
        .err         (err),
        .busy        (busy),
        .fsm_trigger (fsm_trigger),
        .fsm_en      (fsm_en),
        .fsm_done    (fsm_done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    bit check_on = 1'b0;
    int ack_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- shared timer stub ----------------
    int timer_max = 0;   // 0: never reports done
    bit noise = 1'b0;    // random stray fsm_done pulses
    int tcnt = 0;

    initial forever begin
        @(negedge clk); #1;
        fsm_done = 1'b0;
        if (!rst_n) begin
            tcnt = 0;
        end else begin
            if (tcnt > 0) begin
                tcnt--;
                if (tcnt == 0) fsm_done = 1'b1;
            end
            if (fsm_trigger && timer_max > 0) tcnt = timer_max;
            if (noise && $urandom_range(0, 15) == 0) fsm_done = 1'b1;
        end
    end

    // ---------------- reference model (job level) ----------------
    int m_owner  = -1;     // requester holding the current job, -1 if none
    int m_last   = N - 1;  // most recent completed winner
    int m_waited = 0;      // enabled cycles spent waiting on the timer
    bit m_trig   = 1'b0;   // this cycle is the job's start pulse
    bit m_ack    = 1'b0;   // this cycle is the job's completion pulse
    bit m_err    = 1'b0;

    // Nearest requester going forward around the ring from last+1.
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        int best;
        int best_d;
        best   = -1;
        best_d = N + 1;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                int d;
                d = (i - last - 1 + N) % N;
                if (d < best_d) begin
                    best_d = d;
                    best   = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_owner = -1; m_last = N - 1; m_waited = 0;
            m_trig = 1'b0; m_ack = 1'b0; m_err = 1'b0;
        end else if (m_ack) begin
            m_last  = m_owner;
            m_owner = -1;
            m_ack   = 1'b0;
            m_err   = 1'b0;
        end else if (m_trig) begin
            m_trig   = 1'b0;
            m_waited = 0;
        end else if (m_owner >= 0) begin
            if (fsm_done) begin
                m_ack = 1'b1;
            end else if (en) begin
                m_waited++;
                if (m_waited == TO) begin
                    m_ack = 1'b1;
                    m_err = 1'b1;
                end
            end
        end else if (en && req != '0) begin
            m_owner = rr_pick(req, m_last);
            m_trig  = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // ---------------- scoreboard: per-cycle comparison ----------------
    task automatic check_cycle();
        logic [N-1:0] one;
        logic [N-1:0] exp_gnt;
        one     = 1;
        exp_gnt = (m_owner >= 0) ? (one << m_owner) : '0;
        chk("gnt", gnt, exp_gnt);
        chk("ack", ack, m_ack ? exp_gnt : '0);
        chk("err", err, m_ack && m_err);
        chk("busy", busy, m_owner >= 0);
        chk("fsm_trigger", fsm_trigger, m_trig);
        chk("fsm_en", fsm_en, en);
        chk("gnt_onehot", $countones(gnt) <= 1, 1);
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n && ack != '0) ack_count++;
        if (rst_n && check_on) check_cycle();
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_trig(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fsm_trigger === 1'b1) begin
                at = cyc;
                break;
            end
        end
        #1;
        chk("trigger_seen", at >= 0, 1);
    endtask

    task automatic wait_ack(input int budget, output int at,
                            output logic [N-1:0] a, output logic e);
        at = -1;
        a  = '0;
        e  = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack !== '0) begin
                at = cyc;
                a  = ack;
                e  = err;
                break;
            end
        end
        #1;
        chk("ack_seen", at >= 0, 1);
    endtask

    // ---------------- directed + random sequence ----------------
    int           t0, t1, acks_before;
    logic [N-1:0] a;
    logic         e;
    logic [N-1:0] one_hot;

    initial begin
        // reset values while held in reset
        rst_n = 1'b0; en = 1'b0; req = '0;
        step(1);
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trig", fsm_trigger, 0);
        rst_n = 1'b1; en = 1'b1;
        check_on = 1'b1;

        // quiet: no requests for 20 cycles
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("quiet_gnt", gnt, 0);
            chk("quiet_trig", fsm_trigger, 0);
            chk("quiet_busy", busy, 0);
        end

        // single job finished by the timer; req dropped mid-job
        timer_max = 20;
        req = 4'b0001;
        wait_trig(5, t0);
        chk("single_gnt", gnt, 4'b0001);
        req = '0;
        wait_ack(200, t1, a, e);
        chk("single_ack", a, 4'b0001);
        chk("single_err", e, 0);
        chk("single_latency", t1 - t0, timer_max + 1);

        // round robin from a fresh reset with all requesting
        rst_n = 1'b0; step(2); rst_n = 1'b1;
        timer_max = 3;
        acks_before = ack_count;
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            one_hot = 4'b0001 << (j % N);
            wait_trig(10, t0);
            chk("rr_gnt", gnt, one_hot);
            wait_ack(50, t1, a, e);
            chk("rr_ack", a, one_hot);
        end
        req = '0;
        step(2);
        chk("rr_ack_count", ack_count - acks_before, 5);

        // watchdog expiry with no timer response
        timer_max = 0;
        req = 4'b0001;
        wait_trig(5, t0);
        req = '0;
        wait_ack(200, t1, a, e);
        chk("wd_ack", a, 4'b0001);
        chk("wd_err", e, 1);
        chk("wd_latency", t1 - t0, TO + 1);

        // enable dropped for 10 cycles while waiting delays the watchdog
        req = 4'b0001;
        wait_trig(5, t0);
        req = '0;
        step(5);
        en = 1'b0;
        step(10);
        en = 1'b1;
        wait_ack(200, t1, a, e);
        chk("wd_en_err", e, 1);
        chk("wd_en_latency", t1 - t0, TO + 11);

        // no grant while disabled in IDLE
        en = 1'b0;
        req = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("dis_gnt", gnt, 0);
            chk("dis_trig", fsm_trigger, 0);
        end
        timer_max = 4;
        en = 1'b1;
        wait_trig(5, t0);
        chk("en_gnt", gnt, 4'b0010);
        req = '0;
        wait_ack(50, t1, a, e);
        chk("en_ack", a, 4'b0010);

        // asynchronous reset while waiting aborts the job silently
        timer_max = 0;
        req = 4'b0001;
        wait_trig(5, t0);
        req = '0;
        step(5);
        acks_before = ack_count;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_gnt", gnt, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ack", ack, 0);
        chk("abort_err", err, 0);
        chk("abort_trig", fsm_trigger, 0);
        step(2);
        rst_n = 1'b1;
        timer_max = 3;
        req = 4'b1000;
        wait_trig(5, t0);
        chk("post_abort_gnt", gnt, 4'b1000);
        req = '0;
        wait_ack(50, t1, a, e);
        chk("post_abort_ack", a, 4'b1000);
        chk("post_abort_acks", ack_count - acks_before, 1);

        // random traffic, stray timer pulses, occasional resets
        noise = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, (1 << N) - 1));
            en = ($urandom_range(0, 9) != 0);
            timer_max = $urandom_range(0, 25);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end else begin
                step(1);
            end
        end
        noise = 1'b0;
        req = '0;
        step(2);
        check_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
